// File: rtl/mc_control_unit_if.sv
// Control/datapath bundle for the multicycle control unit: decode inputs,
// memory handshake, and the mux selects / strobes driven back to the datapath.
interface mc_control_unit_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero_flag;
   logic       mem_ready;
   logic [3:0] alu_op;
   logic [1:0] a_sel;
   logic [2:0] b_sel;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] wb_sel;
   logic       illegal;
   logic       bus_err;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero_flag, mem_ready,
      output alu_op, a_sel, b_sel, pc_write, pc_src, ir_write, iord,
             mem_read, mem_write, reg_write, reg_dst, wb_sel,
             illegal, bus_err, state
   );

   modport slave (
      output opcode, funct, zero_flag, mem_ready,
      input  alu_op, a_sel, b_sel, pc_write, pc_src, ir_write, iord,
             mem_read, mem_write, reg_write, reg_dst, wb_sel,
             illegal, bus_err, state
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout.
// Optional jal support is enabled by defining MC_CTRL_JAL_EN.
module mc_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   mc_control_unit_if.master  bus
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_BNE  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_AND  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_LUI  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_R_WB     = 4'd3,
      S_EXEC_I   = 4'd4,
      S_I_WB     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL_LINK = 4'd12,
      S_ILLEGAL  = 4'd13,
      S_BUS_ERR  = 4'd14
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_hit_c;
   logic             mem_state_c;

   logic [3:0] alu_op_c;
   logic [1:0] a_sel_c;
   logic [2:0] b_sel_c;
   logic       pc_write_c;
   logic [1:0] pc_src_c;
   logic       ir_write_c;
   logic       iord_c;
   logic       mem_read_c;
   logic       mem_write_c;
   logic       reg_write_c;
   logic [1:0] reg_dst_c;
   logic [1:0] wb_sel_c;
   logic       illegal_c;
   logic       bus_err_c;

   // A wait that reaches the limit loses only if mem_ready is still low in that cycle.
   assign tmo_hit_c   = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));
   assign mem_state_c = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_op_c    = ALU_ADD;
      a_sel_c     = 2'd0;
      b_sel_c     = 3'd0;
      pc_write_c  = 1'b0;
      pc_src_c    = 2'd0;
      ir_write_c  = 1'b0;
      iord_c      = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      reg_write_c = 1'b0;
      reg_dst_c   = 2'd0;
      wb_sel_c    = 2'd0;
      illegal_c   = 1'b0;
      bus_err_c   = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read_c = 1'b1;
            b_sel_c    = 3'd1;
            if (bus.mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (tmo_hit_c) begin
               state_d = S_BUS_ERR;
            end
         end
         S_DECODE: begin
            b_sel_c = 3'd4;
            case (bus.opcode)
               OP_RTYPE:        state_d = S_EXEC_R;
               OP_LW, OP_SW:    state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE:  state_d = S_BRANCH;
               OP_J:            state_d = S_JUMP;
`ifdef MC_CTRL_JAL_EN
               OP_JAL:          state_d = S_JAL_LINK;
`endif
               OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
               OP_ORI, OP_XORI, OP_LUI: state_d = S_EXEC_I;
               default:         state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R: begin
            a_sel_c = 2'd1;
            state_d = S_R_WB;
            case (bus.funct)
               F_ADD:  alu_op_c = ALU_ADD;
               F_SUB:  alu_op_c = ALU_SUB;
               F_AND:  alu_op_c = ALU_AND;
               F_OR:   alu_op_c = ALU_OR;
               F_XOR:  alu_op_c = ALU_XOR;
               F_NOR:  alu_op_c = ALU_NOR;
               F_SLT:  alu_op_c = ALU_SLT;
               F_SLTU: alu_op_c = ALU_SLTU;
               F_SLL: begin
                  alu_op_c = ALU_SLL;
                  a_sel_c  = 2'd2;
               end
               F_SRL: begin
                  alu_op_c = ALU_SRL;
                  a_sel_c  = 2'd2;
               end
               F_SRA: begin
                  alu_op_c = ALU_SRA;
                  a_sel_c  = 2'd3;
                  b_sel_c  = 3'd5;
               end
               F_JR: begin
                  pc_write_c = 1'b1;
                  pc_src_c   = 2'd3;
                  state_d    = S_FETCH;
               end
               default: state_d = S_ILLEGAL;
            endcase
         end
         S_R_WB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 2'd1;
            state_d     = S_FETCH;
         end
         S_EXEC_I: begin
            a_sel_c = 2'd1;
            b_sel_c = 3'd2;
            state_d = S_I_WB;
            case (bus.opcode)
               OP_SLTI:  alu_op_c = ALU_SLT;
               OP_SLTIU: alu_op_c = ALU_SLTU;
               OP_ANDI: begin
                  alu_op_c = ALU_AND;
                  b_sel_c  = 3'd3;
               end
               OP_ORI: begin
                  alu_op_c = ALU_OR;
                  b_sel_c  = 3'd3;
               end
               OP_XORI: begin
                  alu_op_c = ALU_XOR;
                  b_sel_c  = 3'd3;
               end
               OP_LUI: begin
                  alu_op_c = ALU_LUI;
                  b_sel_c  = 3'd3;
               end
               default: alu_op_c = ALU_ADD;
            endcase
         end
         S_I_WB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEM_ADDR: begin
            a_sel_c = 2'd1;
            b_sel_c = 3'd2;
            state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read_c = 1'b1;
            iord_c     = 1'b1;
            if (bus.mem_ready)   state_d = S_MEM_WB;
            else if (tmo_hit_c)  state_d = S_BUS_ERR;
         end
         S_MEM_WB: begin
            reg_write_c = 1'b1;
            wb_sel_c    = 2'd1;
            state_d     = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write_c = 1'b1;
            iord_c      = 1'b1;
            if (bus.mem_ready)   state_d = S_FETCH;
            else if (tmo_hit_c)  state_d = S_BUS_ERR;
         end
         S_BRANCH: begin
            a_sel_c    = 2'd1;
            alu_op_c   = (bus.opcode == OP_BEQ) ? ALU_SUB : ALU_BNE;
            pc_write_c = bus.zero_flag;
            pc_src_c   = 2'd1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'd2;
            state_d    = S_FETCH;
         end
`ifdef MC_CTRL_JAL_EN
         S_JAL_LINK: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 2'd2;
            wb_sel_c    = 2'd2;
            pc_write_c  = 1'b1;
            pc_src_c    = 2'd2;
            state_d     = S_FETCH;
         end
`endif
         S_ILLEGAL: illegal_c = 1'b1;
         S_BUS_ERR: bus_err_c = 1'b1;
         default:   state_d   = S_FETCH;
      endcase

      // Wait counter restarts on every state change and only runs while stalled.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (mem_state_c && !bus.mem_ready && (MEM_TIMEOUT != 0)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Write strobes must not leak while reset is held, even with mem_ready high.
      if (!rst_n) begin
         pc_write_c  = 1'b0;
         ir_write_c  = 1'b0;
         reg_write_c = 1'b0;
         mem_write_c = 1'b0;
      end
   end

   assign bus.alu_op    = alu_op_c;
   assign bus.a_sel     = a_sel_c;
   assign bus.b_sel     = b_sel_c;
   assign bus.pc_write  = pc_write_c;
   assign bus.pc_src    = pc_src_c;
   assign bus.ir_write  = ir_write_c;
   assign bus.iord      = iord_c;
   assign bus.mem_read  = mem_read_c;
   assign bus.mem_write = mem_write_c;
   assign bus.reg_write = reg_write_c;
   assign bus.reg_dst   = reg_dst_c;
   assign bus.wb_sel    = wb_sel_c;
   assign bus.illegal   = illegal_c;
   assign bus.bus_err   = bus_err_c;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: each instruction is expanded into its
// phase list and every cycle's controls are compared against per-phase rules.
module tb_mc_control_unit;

   localparam int unsigned TMO   = 4;
   localparam int          NEVER = 1000;

   typedef enum {P_FETCH, P_DECODE, P_EXEC_R, P_R_WB, P_EXEC_I, P_I_WB, P_MEM_ADDR,
                 P_MEM_RD, P_MEM_WB, P_MEM_WR, P_BRANCH, P_JUMP, P_JAL, P_ILLEGAL,
                 P_BUS_ERR} ph_e;
   typedef ph_e ph_q_t[$];

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [5:0] fpool [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08};

   mc_control_unit_if bus_if ();

   mc_control_unit #(.MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_strb(input string n, input int pcw, input int irw, input int rw,
                           input int mw, input int mr);
      check_eq({n, ".pc_write"},  32'(bus_if.pc_write),  pcw);
      check_eq({n, ".ir_write"},  32'(bus_if.ir_write),  irw);
      check_eq({n, ".reg_write"}, 32'(bus_if.reg_write), rw);
      check_eq({n, ".mem_write"}, 32'(bus_if.mem_write), mw);
      check_eq({n, ".mem_read"},  32'(bus_if.mem_read),  mr);
   endtask

   task automatic chk_alu(input string n, input int alu, input int a, input int b);
      check_eq({n, ".alu_op"}, 32'(bus_if.alu_op), alu);
      check_eq({n, ".a_sel"},  32'(bus_if.a_sel),  a);
      check_eq({n, ".b_sel"},  32'(bus_if.b_sel),  b);
   endtask

   function automatic bit r_legal(input logic [5:0] fn);
      return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                        6'h00, 6'h02, 6'h03, 6'h08};
   endfunction

   // Instruction -> sequence of phases it must walk through.
   function automatic ph_q_t phases(input logic [5:0] op, input logic [5:0] fn);
      ph_q_t q;
      q.push_back(P_FETCH);
      q.push_back(P_DECODE);
      case (op)
         6'h00: begin
            q.push_back(P_EXEC_R);
            if (fn != 6'h08) q.push_back(r_legal(fn) ? P_R_WB : P_ILLEGAL);
         end
         6'h23: begin q.push_back(P_MEM_ADDR); q.push_back(P_MEM_RD); q.push_back(P_MEM_WB); end
         6'h2b: begin q.push_back(P_MEM_ADDR); q.push_back(P_MEM_WR); end
         6'h04, 6'h05: q.push_back(P_BRANCH);
         6'h02: q.push_back(P_JUMP);
`ifdef MC_CTRL_JAL_EN
         6'h03: q.push_back(P_JAL);
`endif
         6'h08, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
            q.push_back(P_EXEC_I);
            q.push_back(P_I_WB);
         end
         default: q.push_back(P_ILLEGAL);
      endcase
      return q;
   endfunction

   task automatic check_phase(input ph_e p, input logic [5:0] op, input logic [5:0] fn,
                              input logic rdy, input logic zf);
      string n;
      int    alu, a, b;
      n = p.name();
      case (p)
         P_FETCH: begin
            chk_strb(n, 32'(rdy), 32'(rdy), 0, 0, 1);
            chk_alu(n, 0, 0, 1);
            check_eq({n, ".iord"},    32'(bus_if.iord),    0);
            check_eq({n, ".pc_src"},  32'(bus_if.pc_src),  0);
            check_eq({n, ".illegal"}, 32'(bus_if.illegal), 0);
            check_eq({n, ".bus_err"}, 32'(bus_if.bus_err), 0);
         end
         P_DECODE: begin
            chk_strb(n, 0, 0, 0, 0, 0);
            chk_alu(n, 0, 0, 4);
         end
         P_EXEC_R: begin
            alu = -1; a = 1; b = 0;
            case (fn)
               6'h20: alu = 0;
               6'h22: alu = 1;
               6'h24: alu = 5;
               6'h25: alu = 6;
               6'h26: alu = 7;
               6'h27: alu = 15;
               6'h2a: alu = 3;
               6'h2b: alu = 4;
               6'h00: begin alu = 9;  a = 2; end
               6'h02: begin alu = 10; a = 2; end
               6'h03: begin alu = 11; a = 3; b = 5; end
               default: alu = -1;
            endcase
            if (fn == 6'h08) begin
               chk_strb(n, 1, 0, 0, 0, 0);
               check_eq({n, ".pc_src"}, 32'(bus_if.pc_src), 3);
            end else begin
               chk_strb(n, 0, 0, 0, 0, 0);
               if (alu >= 0) chk_alu(n, alu, a, b);
            end
         end
         P_R_WB: begin
            chk_strb(n, 0, 0, 1, 0, 0);
            check_eq({n, ".reg_dst"}, 32'(bus_if.reg_dst), 1);
            check_eq({n, ".wb_sel"},  32'(bus_if.wb_sel),  0);
         end
         P_EXEC_I: begin
            case (op)
               6'h08:   alu = 0;
               6'h0a:   alu = 3;
               6'h0b:   alu = 4;
               6'h0c:   alu = 5;
               6'h0d:   alu = 6;
               6'h0e:   alu = 7;
               default: alu = 8;
            endcase
            b = (op inside {6'h08, 6'h0a, 6'h0b}) ? 2 : 3;
            chk_strb(n, 0, 0, 0, 0, 0);
            chk_alu(n, alu, 1, b);
         end
         P_I_WB: begin
            chk_strb(n, 0, 0, 1, 0, 0);
            check_eq({n, ".reg_dst"}, 32'(bus_if.reg_dst), 0);
            check_eq({n, ".wb_sel"},  32'(bus_if.wb_sel),  0);
         end
         P_MEM_ADDR: begin
            chk_strb(n, 0, 0, 0, 0, 0);
            chk_alu(n, 0, 1, 2);
         end
         P_MEM_RD: begin
            chk_strb(n, 0, 0, 0, 0, 1);
            check_eq({n, ".iord"}, 32'(bus_if.iord), 1);
         end
         P_MEM_WB: begin
            chk_strb(n, 0, 0, 1, 0, 0);
            check_eq({n, ".reg_dst"}, 32'(bus_if.reg_dst), 0);
            check_eq({n, ".wb_sel"},  32'(bus_if.wb_sel),  1);
         end
         P_MEM_WR: begin
            chk_strb(n, 0, 0, 0, 1, 0);
            check_eq({n, ".iord"}, 32'(bus_if.iord), 1);
         end
         P_BRANCH: begin
            chk_strb(n, 32'(zf), 0, 0, 0, 0);
            chk_alu(n, (op == 6'h04) ? 1 : 2, 1, 0);
            check_eq({n, ".pc_src"}, 32'(bus_if.pc_src), 1);
         end
         P_JUMP: begin
            chk_strb(n, 1, 0, 0, 0, 0);
            check_eq({n, ".pc_src"}, 32'(bus_if.pc_src), 2);
         end
         P_JAL: begin
            chk_strb(n, 1, 0, 1, 0, 0);
            check_eq({n, ".pc_src"},  32'(bus_if.pc_src),  2);
            check_eq({n, ".reg_dst"}, 32'(bus_if.reg_dst), 2);
            check_eq({n, ".wb_sel"},  32'(bus_if.wb_sel),  2);
         end
         P_ILLEGAL: begin
            chk_strb(n, 0, 0, 0, 0, 0);
            check_eq({n, ".illegal"}, 32'(bus_if.illegal), 1);
            check_eq({n, ".bus_err"}, 32'(bus_if.bus_err), 0);
         end
         default: begin
            chk_strb(n, 0, 0, 0, 0, 0);
            check_eq({n, ".bus_err"}, 32'(bus_if.bus_err), 1);
            check_eq({n, ".illegal"}, 32'(bus_if.illegal), 0);
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset with mem_ready high, holds it across an edge, then releases.
   task automatic do_reset();
      rst_n = 1'b0;
      bus_if.mem_ready = 1'b1;
      #1;
      chk_strb("RST", 0, 0, 0, 0, 1);
      check_eq("RST.illegal", 32'(bus_if.illegal), 0);
      check_eq("RST.bus_err", 32'(bus_if.bus_err), 0);
      tick();
      chk_strb("RST_HOLD", 0, 0, 0, 0, 1);
      rst_n = 1'b1;
      bus_if.mem_ready = 1'b0;
      #1;
      check_eq("REL.mem_read", 32'(bus_if.mem_read), 1);
      check_eq("REL.iord",     32'(bus_if.iord),     0);
      check_eq("REL.ir_write", 32'(bus_if.ir_write), 0);
   endtask

   // fwait/mwait: idle cycles before mem_ready (NEVER forces a timeout).
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                            input int mwait, input int zfo, input bit rst_wr);
      ph_q_t q;
      q = phases(op, fn);
      bus_if.opcode = op;
      bus_if.funct  = fn;
      foreach (q[i]) begin
         ph_e  p;
         logic zf;
         int   w;
         p  = q[i];
         zf = (zfo < 0) ? 1'($urandom) : 1'(zfo);
         if (p == P_FETCH || p == P_MEM_RD || p == P_MEM_WR) begin
            w = (p == P_FETCH) ? fwait : mwait;
            for (int c = 0; c <= int'(TMO); c++) begin
               logic rdy;
               rdy = (c == w);
               bus_if.mem_ready = rdy;
               bus_if.zero_flag = 1'($urandom);
               #4;
               check_phase(p, op, fn, rdy, 1'b0);
               if (rst_wr && p == P_MEM_WR && c == 1) begin
                  #1;
                  do_reset();
                  return;
               end
               if (!rdy && c == int'(TMO)) begin
                  for (int k = 0; k < 2; k++) begin
                     tick();
                     bus_if.mem_ready = 1'($urandom);
                     #4;
                     check_phase(P_BUS_ERR, op, fn, 1'b0, 1'b0);
                  end
                  tick();
                  do_reset();
                  return;
               end
               tick();
               if (rdy) break;
            end
         end else if (p == P_ILLEGAL) begin
            for (int k = 0; k < 3; k++) begin
               bus_if.mem_ready = 1'($urandom);
               bus_if.zero_flag = 1'($urandom);
               #4;
               check_phase(p, op, fn, 1'b0, 1'b0);
               tick();
            end
            do_reset();
            return;
         end else begin
            bus_if.mem_ready = 1'($urandom);
            bus_if.zero_flag = zf;
            #4;
            check_phase(p, op, fn, 1'b0, zf);
            tick();
         end
      end
   endtask

   function automatic logic [5:0] pick_op();
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 4)       return 6'h00;
      else if (r == 4) return 6'h23;
      else if (r == 5) return 6'h2b;
      else if (r == 6) return 6'h04;
      else if (r == 7) return 6'h05;
      else if (r == 8) return 6'h02;
      else if (r == 9) return 6'h03;
      else if (r < 15) return 6'(8 + $urandom_range(0, 7));
      else             return 6'($urandom);
   endfunction

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 39));
      if (r < 24)      return 0;
      else if (r < 34) return int'($urandom_range(1, 3));
      else if (r < 39) return int'(TMO);
      else             return NEVER;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op, fn;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus_if.opcode    = 6'h00;
      bus_if.funct     = 6'h20;
      bus_if.zero_flag = 1'b0;
      bus_if.mem_ready = 1'b0;
      #3;
      do_reset();

      run_instr(6'h00, 6'h20, 0, 0, -1, 1'b0);       // add, zero-wait
      run_instr(6'h23, 6'h00, 0, 3, -1, 1'b0);       // lw, 3 stall cycles
      run_instr(6'h05, 6'h00, 0, 0, 1, 1'b0);        // bne taken
      run_instr(6'h04, 6'h00, 0, 0, 0, 1'b0);        // beq not taken
      run_instr(6'h00, 6'h03, 0, 0, -1, 1'b0);       // sra
      run_instr(6'h3f, 6'h00, 0, 0, -1, 1'b0);       // illegal opcode
      run_instr(6'h00, 6'h20, NEVER, 0, -1, 1'b0);   // fetch timeout
      run_instr(6'h00, 6'h20, int'(TMO), 0, -1, 1'b0); // ready exactly at limit
      run_instr(6'h2b, 6'h00, 0, NEVER, -1, 1'b1);   // reset mid store
      run_instr(6'h2b, 6'h00, 0, int'(TMO), -1, 1'b0);
      run_instr(6'h23, 6'h00, 1, NEVER, -1, 1'b0);   // load timeout
      run_instr(6'h03, 6'h00, 0, 0, -1, 1'b0);       // jal
      run_instr(6'h00, 6'h08, 0, 0, -1, 1'b0);       // jr
      run_instr(6'h02, 6'h00, 0, 0, -1, 1'b0);       // j
      run_instr(6'h00, 6'h00, 0, 0, -1, 1'b0);       // sll
      run_instr(6'h00, 6'h02, 0, 0, -1, 1'b0);       // srl
      run_instr(6'h0f, 6'h00, 0, 0, -1, 1'b0);       // lui
      run_instr(6'h00, 6'h3f, 0, 0, -1, 1'b0);       // unknown funct

      for (int i = 0; i < 300; i++) begin
         op = pick_op();
         fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fpool[$urandom_range(0, 11)];
         run_instr(op, fn, pick_wait(), pick_wait(), -1, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multicycle control FSM that drives the ALU's 4-bit op code and consumes its zero_flag, turning the processor into a multicycle MIPS-subset core.
- Fetches and decodes each instruction, sequences execute, memory and writeback phases, and issues datapath mux selects and write strobes.
- Handshakes with a shared instruction/data memory through mem_ready.
- The datapath latches IR, A, B, ALUOut and MDR every cycle unless a strobe states otherwise.

Parameters:
MEM_TIMEOUT, 255, maximum cycles spent waiting for mem_ready in any memory state; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero_flag  in  1  from ALU; already inverted by the ALU when op=0010
mem_ready  in  1  memory completes the access this cycle
alu_op  out  4  ALU op: ADD 0000, SUB 0001, BNE-SUB 0010, SLT 0011, SLTU 0100, AND 0101, OR 0110, XOR 0111, LUI 1000, SLL 1001, SRL 1010, SRA 1011, NOR 1111
a_sel  out  2  ALU in1 select: 0 PC, 1 A, 2 shamt, 3 B
b_sel  out  3  ALU in2 select: 0 B, 1 const 4, 2 imm sign-extended, 3 imm zero-extended, 4 sign-extended imm<<2, 5 shamt
pc_write  out  1  load PC
pc_src  out  2  PC source: 0 ALU result, 1 ALUOut, 2 jump target {PC[31:28],IR[25:0],2'b00}, 3 A
ir_write  out  1  load IR
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
reg_dst  out  2  destination register: 0 rt, 1 rd, 2 r31
wb_sel  out  2  writeback data: 0 ALUOut, 1 MDR, 2 PC
illegal  out  1  sticky flag: unknown opcode/funct
bus_err  out  1  sticky flag: memory timeout
state  out  4  current state, for debug

Behaviour:
Outputs:
- All outputs are Moore-decoded from state, with two exceptions: mem_ready gates strobes in memory states, and zero_flag gates pc_write in BRANCH.
- While rst_n=0: state=FETCH; pc_write, ir_write, reg_write and mem_write are forced to 0; illegal=0; bus_err=0; timeout counter=0.

States:
- FETCH: mem_read=1, iord=0, a_sel=0, b_sel=1, alu_op=ADD, pc_src=0. Holds until mem_ready. In the mem_ready cycle, ir_write=1 and pc_write=1, then go to DECODE.
- DECODE: a_sel=0, b_sel=4, alu_op=ADD (branch target lands in ALUOut).
  - Next state: R-type (000000) -> EXEC_R; lw 100011 / sw 101011 -> MEM_ADDR; beq 000100 / bne 000101 -> BRANCH; j 000010 -> JUMP.
  - addi 001000, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, lui 001111 -> EXEC_I.
  - Any other opcode -> ILLEGAL.
- EXEC_R: a_sel=1, b_sel=0.
  - funct to alu_op: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU.
  - sll 000000 and srl 000010: a_sel=2, b_sel=0. sra 000011: a_sel=3, b_sel=5, alu_op=SRA.
  - jr 001000: pc_write=1, pc_src=3, then FETCH.
  - Other legal funct -> R_WB. Unknown funct -> ILLEGAL.
- R_WB: reg_write=1, reg_dst=1, wb_sel=0, then FETCH.
- EXEC_I: a_sel=1.
  - b_sel=2 for addi/slti/sltiu; b_sel=3 for andi/ori/xori/lui.
  - alu_op: ADD, SLT, SLTU, AND, OR, XOR, LUI respectively.
  - Then I_WB.
- I_WB: reg_write=1, reg_dst=0, wb_sel=0, then FETCH.
- MEM_ADDR: a_sel=1, b_sel=2, alu_op=ADD; then MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1; holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, wb_sel=1, then FETCH.
- MEM_WR: mem_write=1, iord=1; holds until mem_ready, then FETCH.
- BRANCH: a_sel=1, b_sel=0, alu_op=SUB for beq or 0010 for bne; pc_write=zero_flag, pc_src=1; then FETCH.
- JUMP: pc_write=1, pc_src=2, then FETCH.
- ILLEGAL: all strobes 0, illegal=1; terminal until reset.
- BUS_ERR: all strobes 0, bus_err=1; terminal until reset.

Cycle counts with zero-wait memory: R/I-type 4, lw 5, sw 4, beq/bne 3, j/jr 3.

Timeout:
- The counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle mem_ready=0.
- When the count reaches MEM_TIMEOUT (and MEM_TIMEOUT!=0), go to BUS_ERR.
- mem_ready in the same cycle the count reaches the limit wins: normal transition.

Reset mid-operation: the next cycle after release is FETCH, and no partial write strobes occur.

Optional Feature:
MC_CTRL_JAL_EN:
- Defined: opcode 000011 (jal) goes from DECODE to JAL_LINK. JAL_LINK asserts reg_write=1, reg_dst=2, wb_sel=2 (PC already holds PC+4), pc_write=1, pc_src=2, then FETCH; 3 cycles total.
- Undefined: 000011 -> ILLEGAL.

Test Plan:
- add (000000/100000), mem_ready=1 always -> FETCH, DECODE, EXEC_R (alu_op=0000, a_sel=1, b_sel=0), R_WB (reg_write=1, reg_dst=1), FETCH: 4 cycles.
- lw with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, iord=1; then MEM_WB reg_write=1, wb_sel=1.
- bne with zero_flag=1 in BRANCH -> alu_op=0010, pc_write=1, pc_src=1; beq with zero_flag=0 -> pc_write=0.
- sra funct 000011 -> a_sel=3, b_sel=5, alu_op=1011; opcode 111111 -> ILLEGAL with illegal=1 held until rst_n pulse.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> BUS_ERR entered after 4 waiting cycles, bus_err=1; mem_ready rising exactly at count 4 -> DECODE instead.
- rst_n asserted mid MEM_WR -> mem_write drops immediately; after release, state=FETCH and mem_read=1.
